// File: rtl/dwc_ibuf.sv
// Elastic first-word-fall-through input buffer for the dwc core: output register plus a (DEPTH-1)-entry ring.
// Optional DWC_IBUF_AFULL_EN adds parameter AFULL and a registered almost-full output afull.
module dwc_ibuf #(
  parameter int BITS  = 8,
  parameter int DEPTH = 4
`ifdef DWC_IBUF_AFULL_EN
  , parameter int AFULL = DEPTH - 1
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       irdy,
  input  logic                       ivld,
  input  logic [BITS-1:0]            idat,
  input  logic                       ordy,
  output logic                       ovld,
  output logic [BITS-1:0]            odat,
`ifdef DWC_IBUF_AFULL_EN
  output logic                       afull,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [BITS-1:0] mem [DEPTH-1];
  logic [PW-1:0]   wptr, rptr;
  logic            wr, rd, mem_wr, mem_rd, load_in;
  logic [CW-1:0]   count_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // The ring holds count-1 words whenever ovld is set; an incoming word goes
  // straight to the output register only when the ring is empty and the
  // register is free (or being read in this same edge).
  always_comb begin
    wr         = ivld && irdy;
    rd         = ovld && ordy;
    mem_rd     = rd && (count > CNT_ONE);
    load_in    = wr && (!ovld || (rd && count == CNT_ONE));
    mem_wr     = wr && !load_in;
    count_next = count;
    if (wr && !rd)
      count_next = count + CNT_ONE;
    else if (rd && !wr)
      count_next = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irdy  <= 1'b0;
      ovld  <= 1'b0;
      odat  <= '0;
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      count <= count_next;
      irdy  <= count_next < CNT_FULL;
      ovld  <= count_next != '0;
      if (load_in)
        odat <= idat;
      else if (mem_rd)
        odat <= mem[rptr];
      if (mem_wr)
        wptr <= ptr_inc(wptr);
      if (mem_rd)
        rptr <= ptr_inc(rptr);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr)
      mem[wptr] <= idat;
  end

`ifdef DWC_IBUF_AFULL_EN
  localparam logic [CW-1:0] CNT_AFULL = CW'(AFULL);

  always_ff @(posedge clk) begin
    if (rst)
      afull <= 1'b0;
    else
      afull <= count_next >= CNT_AFULL;
  end
`endif

`ifndef SYNTHESIS
  logic            stall_q;
  logic [BITS-1:0] odat_q;

  always_ff @(posedge clk) begin
    stall_q <= !rst && ovld && !ordy;
    odat_q  <= odat;
    if (stall_q)
      assert (ovld && odat == odat_q);
    assert (count <= CNT_FULL);
  end
`endif

endmodule

// File: tb/tb_dwc_ibuf.sv
// Self-checking bench for dwc_ibuf: directed DEPTH=4 cases, DEPTH=3 streaming, DEPTH=5 random vs queue model.
module tb_dwc_ibuf;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Instance A: BITS=8, DEPTH=4 (directed)
  logic       a_irdy, a_ivld, a_ordy, a_ovld;
  logic [7:0] a_idat, a_odat;
  logic [2:0] a_count;
  // Instance C: BITS=8, DEPTH=3 (streaming)
  logic       c_irdy, c_ivld, c_ordy, c_ovld;
  logic [7:0] c_idat, c_odat;
  logic [1:0] c_count;
  // Instance B: BITS=13, DEPTH=5 (random)
  logic        b_irdy, b_ivld, b_ordy, b_ovld;
  logic [12:0] b_idat, b_odat;
  logic [2:0]  b_count;
`ifdef DWC_IBUF_AFULL_EN
  logic a_afull, b_afull, c_afull;
`endif

  dwc_ibuf #(.BITS(8), .DEPTH(4)
`ifdef DWC_IBUF_AFULL_EN
    , .AFULL(3)
`endif
  ) u_a (
    .clk(clk), .rst(rst), .irdy(a_irdy), .ivld(a_ivld), .idat(a_idat),
    .ordy(a_ordy), .ovld(a_ovld), .odat(a_odat),
`ifdef DWC_IBUF_AFULL_EN
    .afull(a_afull),
`endif
    .count(a_count));

  dwc_ibuf #(.BITS(8), .DEPTH(3)) u_c (
    .clk(clk), .rst(rst), .irdy(c_irdy), .ivld(c_ivld), .idat(c_idat),
    .ordy(c_ordy), .ovld(c_ovld), .odat(c_odat),
`ifdef DWC_IBUF_AFULL_EN
    .afull(c_afull),
`endif
    .count(c_count));

  dwc_ibuf #(.BITS(13), .DEPTH(5)) u_b (
    .clk(clk), .rst(rst), .irdy(b_irdy), .ivld(b_ivld), .idat(b_idat),
    .ordy(b_ordy), .ovld(b_ovld), .odat(b_odat),
`ifdef DWC_IBUF_AFULL_EN
    .afull(b_afull),
`endif
    .count(b_count));

  logic [12:0] q[$];

  initial begin
    int cnt;
    logic mwr, mrd;
    rst = 1'b1;
    a_ivld = 1'b0; a_ordy = 1'b0; a_idat = '0;
    c_ivld = 1'b0; c_ordy = 1'b0; c_idat = '0;
    b_ivld = 1'b0; b_ordy = 1'b0; b_idat = '0;
    step; step;

    // Reset state
    check("rst_irdy", 32'(a_irdy), 0);
    check("rst_ovld", 32'(a_ovld), 0);
    check("rst_count", 32'(a_count), 0);
    check("rst_odat", 32'(a_odat), 0);
`ifdef DWC_IBUF_AFULL_EN
    check("rst_afull", 32'(a_afull), 0);
`endif
    rst = 1'b0;
    step;
    check("post_rst_irdy", 32'(a_irdy), 1);
    check("post_rst_ovld", 32'(a_ovld), 0);
    check("post_rst_count", 32'(a_count), 0);

    // Single word
    a_ivld = 1'b1; a_idat = 8'hA5; a_ordy = 1'b1;
    step;
    a_ivld = 1'b0;
    check("single_ovld", 32'(a_ovld), 1);
    check("single_odat", 32'(a_odat), 32'h A5);
    check("single_count", 32'(a_count), 1);
    check("single_irdy", 32'(a_irdy), 1);
    step;
    check("single_count0", 32'(a_count), 0);
    check("single_ovld0", 32'(a_ovld), 0);
    check("single_irdy1", 32'(a_irdy), 1);

    // Fill with output stalled; words 5 and 6 must be refused
    a_ordy = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      a_ivld = 1'b1; a_idat = 8'(i);
      step;
      cnt = (i < 4) ? i : 4;
      check("fill_count", 32'(a_count), 32'(cnt));
      check("fill_irdy", 32'(a_irdy), 32'(i < 4));
      check("fill_ovld", 32'(a_ovld), 1);
      check("fill_odat", 32'(a_odat), 1);
`ifdef DWC_IBUF_AFULL_EN
      check("fill_afull", 32'(a_afull), 32'(cnt >= 3));
`endif
    end
    a_ivld = 1'b0;

    // Drain
    a_ordy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_ovld", 32'(a_ovld), 1);
      check("drain_odat", 32'(a_odat), 32'(i));
      step;
      check("drain_count", 32'(a_count), 32'(4 - i));
      check("drain_irdy", 32'(a_irdy), 1);
`ifdef DWC_IBUF_AFULL_EN
      check("drain_afull", 32'(a_afull), 32'((4 - i) >= 3));
`endif
    end
    check("drain_empty", 32'(a_ovld), 0);

    // Reset mid-operation
    a_ordy = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      a_ivld = 1'b1; a_idat = 8'(i * 17);
      step;
    end
    a_ivld = 1'b0;
    check("mid_count3", 32'(a_count), 3);
    rst = 1'b1;
    step;
    rst = 1'b0;
    check("mid_ovld", 32'(a_ovld), 0);
    check("mid_count", 32'(a_count), 0);
    check("mid_irdy0", 32'(a_irdy), 0);
`ifdef DWC_IBUF_AFULL_EN
    check("mid_afull", 32'(a_afull), 0);
`endif
    step;
    check("mid_irdy1", 32'(a_irdy), 1);
    check("mid_ovld_idle", 32'(a_ovld), 0);
    a_ivld = 1'b1; a_idat = 8'h44; a_ordy = 1'b1;
    step;
    a_ivld = 1'b0;
    check("mid_new_odat", 32'(a_odat), 32'h44);
    check("mid_new_count", 32'(a_count), 1);
    step;
    check("mid_after_ovld", 32'(a_ovld), 0);

    // Streaming through DEPTH=3
    c_ivld = 1'b1; c_ordy = 1'b1;
    for (int k = 0; k < 100; k++) begin
      c_idat = 8'(k);
      step;
      check("stream_ovld", 32'(c_ovld), 1);
      check("stream_odat", 32'(c_odat), 32'(k & 8'hFF));
      check("stream_count", 32'(c_count), 1);
      check("stream_irdy", 32'(c_irdy), 1);
    end
    c_ivld = 1'b0; c_ordy = 1'b0;

    // Random throttling against a queue model, DEPTH=5
    q.delete();
    for (int n = 0; n < 10000; n++) begin
      check("rnd_count", 32'(b_count), 32'(q.size()));
      check("rnd_irdy", 32'(b_irdy), 32'(q.size() < 5));
      check("rnd_ovld", 32'(b_ovld), 32'(q.size() > 0));
      if (q.size() > 0)
        check("rnd_odat", 32'(b_odat), 32'(q[0]));
      b_ivld = 1'(($urandom() & 1));
      b_ordy = 1'(($urandom() & 1));
      b_idat = 13'($urandom());
      mwr = b_ivld && (q.size() < 5);
      mrd = b_ordy && (q.size() > 0);
      step;
      if (mrd) void'(q.pop_front());
      if (mwr) q.push_back(b_idat);
    end
    b_ivld = 1'b0; b_ordy = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
